// File: rtl/cd_rx_dma_pkg.sv
// Shared types and sizing for the rx frame-RAM read sequencer.
package cd_rx_dma_pkg;
    typedef enum logic [2:0] {IDLE, CHK, READ, DRAIN, DONE, GAP} state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/cd_rx_dma_fifo.sv
// Small output FIFO (byte + last flag); head visible the cycle after push.
// No internal guarding: caller never pushes when full or pops when empty.
module cd_rx_dma_fifo
    import cd_rx_dma_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop,
    output logic [W-1:0]          head_dat,
    output logic [FIFO_CNT_W-1:0] cnt
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [W-1:0]          mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_q];
    assign cnt      = cnt_q;
endmodule

// File: rtl/cd_rx_dma_ctrl.sv
// Rx frame-RAM read sequencer: drains frames onto a byte stream (1 byte/cycle, 2-deep output FIFO)
// and shares the RAM read port with CSR reads; m_ready low stalls the engine indefinitely.
module cd_rx_dma_ctrl
    import cd_rx_dma_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int GAP_CYC   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dma_en,
    input  logic                 unread,
    input  logic                 rd_err,
    input  logic [7:0]           rd_frm_len,
    input  logic [7:0]           rd_byte,
    output logic [7:0]           rd_addr,
    output logic                 rd_en,
    output logic                 rd_done,
    input  logic                 csr_rd_en,
    input  logic [7:0]           csr_rd_addr,
    input  logic                 csr_rd_done,
    output logic                 csr_rd_gnt,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 busy
);
    localparam int OCC_W = FIFO_CNT_W + 1;

    state_t                state_q, state_d;
    logic [8:0]            addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic [7:0]            gap_q, gap_d;
    logic                  infl_q, infl_d;
    logic                  last_q, last_d;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [8:0]            head;
    logic [OCC_W-1:0]      occ;
    logic                  pop, issue_ok, eng_rd_en, eng_own, at_last;

    assign m_valid = (fifo_cnt != '0);
    assign pop     = m_valid & m_ready;

    // Occupancy the FIFO will have once the in-flight read lands; one more read may issue below depth.
    assign occ       = {1'b0, fifo_cnt} + {{FIFO_CNT_W{1'b0}}, infl_q} - {{FIFO_CNT_W{1'b0}}, pop};
    assign issue_ok  = occ < OCC_W'(FIFO_DEPTH);
    assign at_last   = (addr_q == {1'b0, len_q});
    assign eng_rd_en = (state_q == READ) && issue_ok;
    assign eng_own   = dma_en || (state_q != IDLE);

    assign rd_en      = ~reset & (eng_rd_en | csr_rd_en);
    assign rd_addr    = reset ? '0 : (eng_rd_en ? addr_q[7:0] : csr_rd_addr);
    assign csr_rd_gnt = ~reset & csr_rd_en & ~eng_rd_en;
    assign rd_done    = ~reset & ((state_q == DONE) | (~eng_own & csr_rd_done));
    assign busy       = (state_q != IDLE);
    assign drop_cnt   = drop_q;
    assign {m_last, m_data} = head;

    cd_rx_dma_fifo #(.W(9)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (infl_q),
        .push_dat ({last_q, rd_byte}),
        .pop      (pop),
        .head_dat (head),
        .cnt      (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        drop_d  = drop_q;
        gap_d   = gap_q;
        infl_d  = eng_rd_en;
        last_d  = eng_rd_en && at_last;
        case (state_q)
            IDLE: if (dma_en && unread) state_d = CHK;
            CHK: begin
                if (rd_err) begin
                    state_d = DONE;
                    if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
                end else begin
                    len_d   = rd_frm_len;
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (eng_rd_en) begin
                    addr_d = addr_q + 9'd1;
                    if (at_last) state_d = DRAIN;
                end
            end
            DRAIN: if (fifo_cnt == '0 && !infl_q) state_d = DONE;
            DONE: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == 8'(GAP_CYC - 1)) state_d = IDLE;
                else                          gap_d   = gap_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            drop_q  <= '0;
            gap_q   <= '0;
            infl_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
            gap_q   <= gap_d;
            infl_q  <= infl_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: doc/cd_rx_dma_ctrl.md
Name: cd_rx_dma_ctrl

Overview:
- Read-side sequencer for the rx frame RAM.
- Owns the RAM read port (rd_addr, rd_en, rd_done) and shares it between the CSR read path and an internal frame-drain engine.
- With dma_en=1 the engine waits for an unread frame, streams every byte (header through CRC) on a valid/ready byte stream, then releases the frame with rd_done. Frames flagged rd_err are dropped and counted.
- With dma_en=0 the CSR path drives the port directly.

Parameters:
- CNT_WIDTH, 8, width of the dropped-frame counter (saturating).
- GAP_CYC, 3, idle cycles after rd_done before unread is sampled again; covers the RAM's 2-cycle unread update.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- dma_en  in  1  1 = engine owns frame release; 0 = CSR pass-through
- unread  in  1  RAM has an unread frame
- rd_err  in  1  current frame has error; valid 1 cycle after unread rises
- rd_frm_len  in  8  current frame length minus 1
- rd_byte  in  8  RAM read data, valid 1 cycle after rd_en
- rd_addr  out  8  RAM read address
- rd_en  out  1  RAM read strobe
- rd_done  out  1  release current frame, 1-cycle pulse
- csr_rd_en  in  1  CSR read request
- csr_rd_addr  in  8  CSR read address
- csr_rd_done  in  1  CSR frame-release request
- csr_rd_gnt  out  1  CSR read accepted this cycle
- m_data  out  8  stream byte
- m_valid  out  1  stream valid
- m_last  out  1  last byte of the frame
- m_ready  in  1  stream sink ready
- drop_cnt  out  CNT_WIDTH  count of error frames dropped, saturating
- busy  out  1  engine not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; output FIFO empty.
- Reset is asynchronous and can assert mid-frame. The frame is not released; it stays unread in the RAM and is re-streamed from byte 0 after reset.

Port mux:
- dma_en=0: rd_addr=csr_rd_addr, rd_en=csr_rd_en, rd_done=csr_rd_done, csr_rd_gnt=csr_rd_en. Engine is held in IDLE.
- dma_en=1: csr_rd_done is ignored.
  - The engine has priority on rd_en.
  - A CSR read is granted (csr_rd_gnt=1, port driven by CSR) only in cycles where the engine does not assert rd_en.
  - CSR data is valid on rd_byte 1 cycle after the grant.

FSM (states IDLE, CHK, READ, DRAIN, DONE, GAP):
- IDLE: if dma_en and unread, go to CHK.
- CHK, one cycle, rd_err now valid:
  - rd_err=1: go to DONE; drop_cnt+1, saturating at all-ones.
  - rd_err=0: latch len=rd_frm_len, set addr counter a=0, go to READ.
- READ: issue rd_en with rd_addr=a whenever issue_ok; then a=a+1.
  - issue_ok = (fifo_cnt + inflight − pop) < 2, where pop = m_valid & m_ready.
  - After issuing a=len, go to DRAIN.
  - Addr counter is 9 bits internally, so len=255 (256 bytes) terminates without wrap.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
- DONE: rd_done=1 for exactly one cycle; go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE. unread is not sampled during GAP.

Output FIFO:
- 2 entries; written on the cycle after rd_en, with data = rd_byte.
- Each entry's last flag is set when it was read from a=len.
- m_valid = FIFO not empty; m_data and m_last come from the head entry.
- Push and pop in the same cycle are allowed.
- With m_ready held high the stream sustains 1 byte per cycle; first byte appears 2 cycles after CHK.
- m_valid is never deasserted and m_data/m_last never change until the head is accepted.

dma_en behaviour:
- Deasserting dma_en mid-frame takes effect only at the next IDLE; the current frame completes.
- m_ready low indefinitely stalls in READ/DRAIN; no timeout.

Decomposition:
- Package cd_rx_dma_pkg holds the state enum (IDLE..GAP) and the constant FIFO_DEPTH=2.
- One sub-module, cd_rx_dma_fifo: the 2-entry, 9-bit-wide (data + last) FIFO with push, pop and count. The FSM and port mux stay in the top module.

Test Plan:
- dma_en=1, unread with rd_frm_len=4, bytes 0xA0..0xA4, m_ready=1 -> 5 beats A0..A4, m_last only on A4; rd_done single pulse after the last beat; busy low GAP_CYC+1 cycles later.
- rd_frm_len=255, m_ready toggling 1/0 each cycle -> exactly 256 beats, no duplicates or drops, addresses 0..255 each read once, one rd_done.
- Error frame: unread=1 with rd_err=1 on the next cycle -> no m_valid; rd_done pulse; drop_cnt 0->1. Repeat 300 times with CNT_WIDTH=8 -> drop_cnt saturates at 255.
- Back-to-back frames with unread kept high -> second CHK no earlier than GAP_CYC cycles after the first rd_done; both frames streamed intact.
- dma_en=1, csr_rd_en held high during READ with m_ready=0 -> csr_rd_gnt=1 only in cycles with engine rd_en=0; csr_rd_done pulses produce no rd_done. dma_en=0 -> csr signals pass straight through.
- Reset asserted mid-frame, after 3 of 6 bytes -> all outputs 0 immediately, FIFO empty, no rd_done. After release with unread still 1 -> full 6-byte frame re-streamed from byte 0.
